amber48_dmem_arb: RTL
=====================

Name: amber48_dmem_arb

Overview:
Round-robin arbiter and sequencer that shares the single amber48_dmem port between NUM_REQ requesters, for example the core LSU (index 0) and the debug/DMA port (index 1). It latches one granted request and issues it to dmem as a one-cycle pulse. If dmem withholds ready (UART back-pressure), it re-issues the request, and it bounds the retries with a trap-on-timeout.

Parameters:
- NUM_REQ, 2, number of requesters; must be >= 2, checked with $fatal.
- RETRY_LIMIT, 255, maximum re-issues of one transaction before a timeout trap; 0 means unlimited.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- req_i  in  NUM_REQ  request per requester; level, held until gnt_o
- we_i  in  NUM_REQ  write enable per requester
- addr_i  in  NUM_REQ x XLEN  byte address per requester
- wdata_i  in  NUM_REQ x XLEN  write data per requester
- gnt_o  out  NUM_REQ  one-cycle grant pulse; request fields are latched this cycle
- rsp_valid_o  out  NUM_REQ  one-cycle response pulse to the owner
- rsp_rdata_o  out  XLEN  response data, broadcast to all requesters
- rsp_trap_o  out  1  response trap, valid with rsp_valid_o
- mem_req_o  out  1  dmem request
- mem_we_o  out  1  dmem write enable
- mem_addr_o  out  XLEN  dmem address
- mem_wdata_o  out  XLEN  dmem write data
- mem_rdata_i  in  XLEN  dmem read data
- mem_ready_i  in  1  dmem ready
- mem_trap_i  in  1  dmem trap

Behaviour:
- Reset (asynchronous):
  - state = IDLE, rr_q = 0, retry_q = 0, owner_q = 0.
  - All outputs are 0, including the latched we/addr/wdata.
- Reset mid-transaction: the transaction is abandoned and no response is produced. This matches dmem, which resets on the same rst_ni.
- IDLE:
  - Scan req_i starting at index rr_q, ascending with wrap-around; the first set bit wins.
  - gnt_o[i] = 1 combinationally in that cycle.
  - Latch we/addr/wdata into mem_*_o registers; owner_q = i; rr_q = (i+1) mod NUM_REQ; retry_q = 0.
  - Next state is ISSUE.
  - No requests: stay in IDLE; rr_q is unchanged.
- ISSUE: mem_req_o = 1 for exactly this cycle. Next state is WAIT.
- WAIT: mem_req_o = 0.
  - mem_ready_i = 1: rsp_valid_o[owner_q] = 1, rsp_rdata_o = mem_rdata_i, rsp_trap_o = mem_trap_i, all combinational. Next state is IDLE.
  - mem_ready_i = 0 and (RETRY_LIMIT == 0 or retry_q < RETRY_LIMIT): retry_q++ (saturating, width $clog2(RETRY_LIMIT+1), minimum 1). Next state is ISSUE; the latched fields are unchanged.
  - mem_ready_i = 0 and retry_q == RETRY_LIMIT (RETRY_LIMIT != 0): rsp_valid_o[owner_q] = 1, rsp_trap_o = 1, rsp_rdata_o = 0. Next state is IDLE.
- Pulsing mem_req_o never holds a request across dmem's registered ready. This guarantees no duplicate write of RAM or the LED.
- mem_ready_i or mem_trap_i arriving in IDLE or ISSUE is ignored.
- When no response is active, rsp_rdata_o = 0 and rsp_trap_o = 0.
- Latency and throughput:
  - Grant in cycle N, mem_req_o in N+1, response in N+2 with no stall.
  - Throughput is one transaction per 3 cycles; each stall adds 2 cycles.
- Requester rules:
  - Hold req/we/addr/wdata stable until gnt_o.
  - Drop req_i, or present the next request, in the cycle after gnt_o.
  - A req_i still high after gnt_o is treated as a new request.
- A grant is never issued in the same cycle as a response; IDLE must be re-entered first.

Optional Feature:
- Macro: AMBER48_DMEM_ARB_STATS_EN.
- When defined, these ports are added:
  - stat_clr_i  in  1  synchronous clear; wins over a same-cycle increment
  - stat_grants_o  out  NUM_REQ x 32  per-requester grant counters, wrapping
  - stat_retries_o  out  32  total re-issues, wrapping
  - stat_timeouts_o  out  16  timeout traps, saturating
- All counters reset to 0.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- amber48_pkg holds XLEN, the arb_state_e enum (IDLE, ISSUE, WAIT), and ARB_RETRY_LIMIT_DEFAULT.
- One natural sub-module: amber48_rr_pick. It is combinational: inputs req and pointer; outputs a one-hot grant and an index.
- The FSM, latches and counters stay in amber48_dmem_arb.

Test Plan:
- Read, requester 0: req_i = 01, addr = 0x30, dmem returns 0x123456789ABC -> gnt_o = 01 in cycle N, mem_req_o only in N+1, rsp_valid_o = 01 with rdata 0x123456789ABC in N+2.
- Contention: req_i = 11 held for 4 transactions -> grant order 0,1,0,1; rr_q alternates; exactly one mem_req_o pulse per grant.
- UART stall: write to the UART index while uart_tx_ready stays low for 3 ISSUE/WAIT pairs -> 3 re-issues, then one write reaches dmem; exactly one uart_tx_valid pulse; rsp_valid_o after the 4th issue.
- Timeout: RETRY_LIMIT = 2, dmem never ready -> 3 mem_req_o pulses total; rsp_trap_o = 1 with rdata 0; state back to IDLE; requester 1 is then serviced.
- Trap passthrough: misaligned address 0x31 -> rsp_trap_o = 1 at N+2 with no retry.
- Reset mid-WAIT: rst_ni low in WAIT -> all outputs 0 asynchronously; no rsp_valid_o after release; first grant goes to index 0.

Source files
------------

// File: rtl/amber48_pkg.sv
// ============================================================================
// Module      : amber48_pkg
// Description : Shared constants and types for the amber48 dmem arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package amber48_pkg;

  localparam int XLEN                    = 48;
  localparam int ARB_RETRY_LIMIT_DEFAULT = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/amber48_rr_pick.sv
// ============================================================================
// Module      : amber48_rr_pick
// Description : Combinational round-robin picker; scans upward from the
//               pointer with wrap-around, and the first set request wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module amber48_rr_pick #(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_valid
);

  logic [PTR_W-1:0] w_cand;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    for (int off = 0; off < N; off++) begin
      w_cand = PTR_W'((32'(i_ptr) + 32'(off)) % N);
      if (!o_valid && i_req[w_cand]) begin
        o_valid       = 1'b1;
        o_idx         = w_cand;
        o_gnt[w_cand] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/amber48_dmem_arb.sv
// ============================================================================
// Module      : amber48_dmem_arb
// Description : Round-robin arbiter/sequencer sharing the amber48 dmem port;
//               pulses each request once, re-issues on stall, traps on timeout.
//               Optional counters: define AMBER48_DMEM_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module amber48_dmem_arb
  import amber48_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int RETRY_LIMIT = ARB_RETRY_LIMIT_DEFAULT
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_REQ-1:0]      req_i,
  input  logic [NUM_REQ-1:0]      we_i,
  input  logic [NUM_REQ*XLEN-1:0] addr_i,
  input  logic [NUM_REQ*XLEN-1:0] wdata_i,
  output logic [NUM_REQ-1:0]      gnt_o,
  output logic [NUM_REQ-1:0]      rsp_valid_o,
  output logic [XLEN-1:0]         rsp_rdata_o,
  output logic                    rsp_trap_o,
`ifdef AMBER48_DMEM_ARB_STATS_EN
  input  logic                    stat_clr_i,
  output logic [NUM_REQ*32-1:0]   stat_grants_o,
  output logic [31:0]             stat_retries_o,
  output logic [15:0]             stat_timeouts_o,
`endif
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [XLEN-1:0]         mem_addr_o,
  output logic [XLEN-1:0]         mem_wdata_o,
  input  logic [XLEN-1:0]         mem_rdata_i,
  input  logic                    mem_ready_i,
  input  logic                    mem_trap_i
);

  localparam int c_ptr_w   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int c_retry_w = (RETRY_LIMIT > 0) ? $clog2(RETRY_LIMIT + 1) : 1;
  localparam logic [c_retry_w-1:0] c_limit = c_retry_w'(RETRY_LIMIT);

  if (NUM_REQ < 2) begin : g_num_req_check
    $fatal(1, "amber48_dmem_arb: NUM_REQ must be >= 2");
  end

  arb_state_e           r_state, w_state_d;
  logic [c_ptr_w-1:0]   r_rr, r_owner;
  logic [c_retry_w-1:0] r_retry;
  logic                 r_we;
  logic [XLEN-1:0]      r_addr, r_wdata;

  logic [NUM_REQ-1:0]   w_pick_gnt;
  logic [c_ptr_w-1:0]   w_pick_idx, w_rr_next;
  logic                 w_pick_valid;
  logic                 w_grant, w_retry;

  amber48_rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (c_ptr_w)
  ) u_rr_pick (
    .i_req   (req_i),
    .i_ptr   (r_rr),
    .o_gnt   (w_pick_gnt),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  assign w_rr_next = (w_pick_idx == c_ptr_w'(NUM_REQ - 1)) ? '0 : w_pick_idx + 1'b1;

  // Grant is gated by rst_ni so every output reads zero while reset is held.
  always_comb begin
    w_state_d   = r_state;
    w_grant     = 1'b0;
    w_retry     = 1'b0;
    gnt_o       = '0;
    rsp_valid_o = '0;
    rsp_rdata_o = '0;
    rsp_trap_o  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_valid && rst_ni) begin
          w_grant   = 1'b1;
          gnt_o     = w_pick_gnt;
          w_state_d = ISSUE;
        end
      end
      ISSUE: w_state_d = WAIT;
      WAIT: begin
        if (mem_ready_i) begin
          rsp_valid_o[r_owner] = 1'b1;
          rsp_rdata_o          = mem_rdata_i;
          rsp_trap_o           = mem_trap_i;
          w_state_d            = IDLE;
        end else if ((RETRY_LIMIT == 0) || (r_retry < c_limit)) begin
          w_retry   = 1'b1;
          w_state_d = ISSUE;
        end else begin
          rsp_valid_o[r_owner] = 1'b1;
          rsp_trap_o           = 1'b1;
          w_state_d            = IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_rr    <= '0;
      r_owner <= '0;
      r_retry <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_grant) begin
        r_owner <= w_pick_idx;
        r_rr    <= w_rr_next;
        r_retry <= '0;
        r_we    <= we_i[w_pick_idx];
        r_addr  <= addr_i[w_pick_idx*XLEN +: XLEN];
        r_wdata <= wdata_i[w_pick_idx*XLEN +: XLEN];
      end else if (w_retry && (r_retry != '1)) begin
        r_retry <= r_retry + c_retry_w'(1);
      end
    end
  end

  // A one-cycle pulse per issue can never be double-counted by dmem's registered ready.
  assign mem_req_o   = (r_state == ISSUE);
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;

`ifdef AMBER48_DMEM_ARB_STATS_EN
  logic [31:0] r_stat_retries;
  logic [15:0] r_stat_timeouts;
  logic        w_timeout;

  assign w_timeout = (r_state == WAIT) && !mem_ready_i && !w_retry;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_grant_cnt
    logic [31:0] r_cnt;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)           r_cnt <= '0;
      else if (stat_clr_i)   r_cnt <= '0;
      else if (gnt_o[g])     r_cnt <= r_cnt + 32'd1;
    end
    assign stat_grants_o[g*32 +: 32] = r_cnt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stat_retries  <= '0;
      r_stat_timeouts <= '0;
    end else if (stat_clr_i) begin
      r_stat_retries  <= '0;
      r_stat_timeouts <= '0;
    end else begin
      if (w_retry)
        r_stat_retries <= r_stat_retries + 32'd1;
      if (w_timeout && (r_stat_timeouts != 16'hFFFF))
        r_stat_timeouts <= r_stat_timeouts + 16'd1;
    end
  end

  assign stat_retries_o  = r_stat_retries;
  assign stat_timeouts_o = r_stat_timeouts;
`endif

endmodule

`default_nettype wire
